hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Hazard/stall controller for the 5-stage MIPS pipeline, sitting at the ID stage.
- Decides whether the instruction in IF/ID advances into ID/EX, which is the register that feeds the EX-stage forwarding logic.
- Handles hazards forwarding cannot resolve: load-use (1 bubble), multi-cycle FP ops occupying EX (FP_LAT-1 freeze cycles), and taken-branch squash.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- FP_LAT, 4, EX-stage occupancy in cycles of a multi-cycle FP op; legal range 1..16.
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rs_IF_ID  in  5  source reg 1 of instruction in ID
- rt_IF_ID  in  5  source reg 2 of instruction in ID
- uses_rs_IF_ID  in  1  ID instruction reads rs
- uses_rt_IF_ID  in  1  ID instruction reads rt
- fp_multi_IF_ID  in  1  ID instruction is a multi-cycle FP op
- MemRead_ID_EX  in  1  instruction in EX is a load
- GeneralRegWrite_ID_EX  in  1  EX instruction writes the GPR file
- FloatRegWrite_ID_EX  in  1  EX instruction writes the FPR file
- write_reg_ID_EX  in  5  destination of EX instruction
- branch_taken_EX  in  1  branch resolved taken in EX this cycle
- stall_cnt_clr  in  1  synchronous clear of stall counter
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_bubble  out  1  load NOP into EX/MEM
- fp_busy  out  1  FSM in FP_BUSY
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- FSM states: RUN, FP_BUSY. Down-counter fp_cnt is 4 bits.
- Reset (rst_n=0, async): state=RUN, fp_cnt=0, stall_cycles=0.
- Outputs during reset: pc_write=1, if_id_write=1, id_ex_write=1; all flush/bubble outputs 0; fp_busy=0.
- Reset asserted mid-FP_BUSY aborts to RUN immediately.
- Control outputs are combinational from state and inputs (Mealy) and must be valid in the same cycle.
- load_use = MemRead_ID_EX && (GeneralRegWrite_ID_EX || FloatRegWrite_ID_EX) && write_reg_ID_EX!=0 && ((uses_rs_IF_ID && rs_IF_ID==write_reg_ID_EX) || (uses_rt_IF_ID && rt_IF_ID==write_reg_ID_EX)).
- Priority, highest first:
  1. FP_BUSY: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1. branch_taken_EX and load_use are ignored.
  2. RUN && branch_taken_EX: if_id_flush=1, id_ex_bubble=1, pc_write=1 (target loads). No FP issue this cycle.
  3. RUN && load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, for exactly 1 cycle. The next cycle the load is in MEM and forwarding covers it.
  4. RUN otherwise: all enables 1, all flush/bubble outputs 0.
- FP issue: RUN && fp_multi_IF_ID && !branch_taken_EX && !load_use && FP_LAT>1.
  - At the clock edge: state<=FP_BUSY, fp_cnt<=FP_LAT-1.
- In FP_BUSY, fp_cnt decrements each edge. When fp_cnt==1, the next state is RUN.
  - FP_BUSY therefore lasts exactly FP_LAT-1 cycles.
  - The FP op spends FP_LAT total cycles in EX.
- FP_LAT==1: the FSM never leaves RUN.
- Back-to-back FP ops: the second one issues from RUN in the cycle after FP_BUSY ends. There are no dead cycles between them.
- stall_cycles:
  - Increments on each edge where pc_write==0.
  - Saturates at all-ones and does not wrap.
  - stall_cnt_clr has priority over increment and sets the counter to 0.
- An x-free register 0 never triggers load-use, even with a matching load destination of 0.

Decomposition:
- Shared package mips_hazard_pkg contains:
  - the state enum {RUN, FP_BUSY};
  - REG_ADDR_W=5;
  - the constant ZERO_REG=5'd0.
- One sub-module: sat_counter (parameterised width, inc, clr, saturating). It is reused for other pipeline perf counters.
- FSM and hazard compare stay in the top module.

Test Plan:
- Load-use: lw $t0 in EX (MemRead=1, GeneralRegWrite=1, write_reg=8) with ID rs=8, uses_rs=1.
  - Required: one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1.
  - Same stimulus with write_reg=0 or uses_rs=0 produces no stall.
- FP op, FP_LAT=4: fp_multi_IF_ID=1 in RUN.
  - Required: fp_busy=1 and ex_mem_bubble=1 for exactly 3 cycles, id_ex_write=0 throughout, then RUN; stall_cycles=3.
- Branch vs load-use: branch_taken_EX=1 and load_use=1 in the same cycle.
  - Required: if_id_flush=1, id_ex_bubble=1, pc_write=1; no stall; no FP issue even if fp_multi_IF_ID=1.
- Reset mid-op: rst_n=0 asserted in the 2nd FP_BUSY cycle.
  - Required: fp_busy=0 and pc_write=1 immediately (asynchronous); after release, state=RUN and stall_cycles=0.
- Counter saturation, CNT_W=4: hold load_use for 20 cycles.
  - Required: stall_cycles stops at 15.
  - Pulse stall_cnt_clr while the stall is still active: counter reads 0 on the next edge.
- FP_LAT=1, with fp_multi_IF_ID=1 for 5 consecutive cycles.
  - Required: fp_busy stays 0 and pc_write stays 1 throughout.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
//   hz_state_e : hazard controller FSM states (RUN, FP_BUSY)
//   REG_ADDR_W : register-file address width
//   ZERO_REG   : hard-wired zero register, never a real dependency
package mips_hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    FP_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for pipeline performance counters.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one event on this edge
//   clr   : synchronous clear, wins over inc
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall controller for the 5-stage MIPS pipeline.
// Decides whether the IF/ID instruction may advance into ID/EX, covering the
// hazards forwarding cannot fix: load-use (one bubble), multi-cycle FP ops
// holding EX (FP_LAT-1 freeze cycles) and taken-branch squash.
// Ports:
//   clk, rst_n             : clock / asynchronous active-low reset
//   rs/rt_IF_ID, uses_*    : source operands of the instruction in ID
//   fp_multi_IF_ID         : ID instruction is a multi-cycle FP op
//   *_ID_EX                : load / write-back info of the instruction in EX
//   branch_taken_EX        : branch resolved taken in EX this cycle
//   stall_cnt_clr          : synchronous clear of stall_cycles
//   pc_write, if_id_write, id_ex_write : pipeline register enables
//   if_id_flush, id_ex_bubble, ex_mem_bubble : NOP injection
//   fp_busy                : an FP op currently occupies EX
//   stall_cycles           : saturating count of cycles with pc_write=0
module hazard_stall_unit
  import mips_hazard_pkg::*;
#(
  parameter int FP_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_IF_ID,
  input  logic [REG_ADDR_W-1:0] rt_IF_ID,
  input  logic                  uses_rs_IF_ID,
  input  logic                  uses_rt_IF_ID,
  input  logic                  fp_multi_IF_ID,
  input  logic                  MemRead_ID_EX,
  input  logic                  GeneralRegWrite_ID_EX,
  input  logic                  FloatRegWrite_ID_EX,
  input  logic [REG_ADDR_W-1:0] write_reg_ID_EX,
  input  logic                  branch_taken_EX,
  input  logic                  stall_cnt_clr,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic                  fp_busy,
  output logic [CNT_W-1:0]      stall_cycles
);

  // Freeze length after issue; FP_LAT is limited to 1..16 so this fits 4 bits.
  localparam logic [3:0] FP_CNT_INIT = 4'(FP_LAT - 1);
  localparam logic       FP_MULTI_EN = (FP_LAT > 1);

  hz_state_e  state_reg, state_next;
  logic [3:0] fp_cnt_reg, fp_cnt_next;
  logic       load_use;
  logic       fp_issue;

  // A load whose destination is read by the ID instruction cannot be
  // forwarded in time; register 0 is never a real dependency.
  always_comb begin
    load_use = MemRead_ID_EX
            && (GeneralRegWrite_ID_EX || FloatRegWrite_ID_EX)
            && (write_reg_ID_EX != ZERO_REG)
            && ((uses_rs_IF_ID && (rs_IF_ID == write_reg_ID_EX))
             || (uses_rt_IF_ID && (rt_IF_ID == write_reg_ID_EX)));
  end

  assign fp_issue = (state_reg == RUN) && fp_multi_IF_ID && !branch_taken_EX
                 && !load_use && FP_MULTI_EN;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      fp_cnt_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      fp_cnt_reg <= fp_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    fp_cnt_next = fp_cnt_reg;
    unique case (state_reg)
      RUN: begin
        if (fp_issue) begin
          state_next  = FP_BUSY;
          fp_cnt_next = FP_CNT_INIT;
        end
      end
      FP_BUSY: begin
        fp_cnt_next = fp_cnt_reg - 4'd1;
        // The <=1 guard also rescues a zero count, which should never occur.
        if (fp_cnt_reg <= 4'd1) begin
          state_next  = RUN;
          fp_cnt_next = 4'd0;
        end
      end
      default: begin
        state_next  = RUN;
        fp_cnt_next = 4'd0;
      end
    endcase
  end

  // Output logic (Mealy). While reset is held the pipeline free-runs so
  // that it can be flushed regardless of what the inputs look like.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    fp_busy       = 1'b0;
    if (rst_n) begin
      if (state_reg == FP_BUSY) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
        fp_busy       = 1'b1;
      end else if (branch_taken_EX) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .clr   (stall_cnt_clr),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit. Two instances share one stimulus stream:
// dut_a (FP_LAT=4, CNT_W=4) and dut_b (FP_LAT=1, CNT_W=8). A cycle-level
// reference model tracks remaining freeze cycles and the stall count.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, wr;
  logic       uses_rs, uses_rt, fp_multi, mem_read, gpr_wr, fpr_wr, branch, clr;

  logic       pc_a, ifw_a, iff_a, idw_a, idb_a, exb_a, busy_a;
  logic       pc_b, ifw_b, iff_b, idw_b, idb_b, exb_b, busy_b;
  logic [3:0] cnt_a;
  logic [7:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: freeze cycles still to come, stall count.
  int m_busy [2];
  int m_cnt  [2];
  int m_lat  [2] = '{4, 1};
  int m_max  [2] = '{15, 255};

  always #5 clk = ~clk;

  hazard_stall_unit #(.FP_LAT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs_IF_ID(rs), .rt_IF_ID(rt),
    .uses_rs_IF_ID(uses_rs), .uses_rt_IF_ID(uses_rt), .fp_multi_IF_ID(fp_multi),
    .MemRead_ID_EX(mem_read), .GeneralRegWrite_ID_EX(gpr_wr),
    .FloatRegWrite_ID_EX(fpr_wr), .write_reg_ID_EX(wr),
    .branch_taken_EX(branch), .stall_cnt_clr(clr),
    .pc_write(pc_a), .if_id_write(ifw_a), .if_id_flush(iff_a),
    .id_ex_write(idw_a), .id_ex_bubble(idb_a), .ex_mem_bubble(exb_a),
    .fp_busy(busy_a), .stall_cycles(cnt_a));

  hazard_stall_unit #(.FP_LAT(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs_IF_ID(rs), .rt_IF_ID(rt),
    .uses_rs_IF_ID(uses_rs), .uses_rt_IF_ID(uses_rt), .fp_multi_IF_ID(fp_multi),
    .MemRead_ID_EX(mem_read), .GeneralRegWrite_ID_EX(gpr_wr),
    .FloatRegWrite_ID_EX(fpr_wr), .write_reg_ID_EX(wr),
    .branch_taken_EX(branch), .stall_cnt_clr(clr),
    .pc_write(pc_b), .if_id_write(ifw_b), .if_id_flush(iff_b),
    .id_ex_write(idw_b), .id_ex_bubble(idb_b), .ex_mem_bubble(exb_b),
    .fp_busy(busy_b), .stall_cycles(cnt_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_load_use();
    bit dep;
    dep = (uses_rs && rs == wr) || (uses_rt && rt == wr);
    return mem_read && (gpr_wr || fpr_wr) && (wr != 5'd0) && dep;
  endfunction

  // Packed as {pc, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, fp_busy}
  function automatic logic [6:0] exp_ctrl(input int i);
    if (!rst_n)          return 7'b1101000;
    if (m_busy[i] > 0)   return 7'b0000011;
    if (branch)          return 7'b1111100;
    if (model_load_use()) return 7'b0001100;
    return 7'b1101000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_edge();
    logic [6:0] c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      c = exp_ctrl(i);
      if (clr)               m_cnt[i] = 0;
      else if (c[6] == 1'b0) m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_max[i];
      if (m_busy[i] > 0)
        m_busy[i]--;
      else if (fp_multi && !branch && !model_load_use() && m_lat[i] > 1)
        m_busy[i] = m_lat[i] - 1;
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One transaction: compare mid-cycle, then advance through the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_eq({tag, "_ctrl_a"}, {25'd0, pc_a, ifw_a, iff_a, idw_a, idb_a, exb_a, busy_a}, {25'd0, exp_ctrl(0)});
    check_eq({tag, "_ctrl_b"}, {25'd0, pc_b, ifw_b, iff_b, idw_b, idb_b, exb_b, busy_b}, {25'd0, exp_ctrl(1)});
    check_eq({tag, "_cnt_a"}, {28'd0, cnt_a}, m_cnt[0]);
    check_eq({tag, "_cnt_b"}, {24'd0, cnt_b}, m_cnt[1]);
    $display("%s t=%0t a:pc=%b busy=%b cnt=%0d b:pc=%b busy=%b cnt=%0d", tag, $time,
             pc_a, busy_a, cnt_a, pc_b, busy_b, cnt_b);
    edge_step();
  endtask

  task automatic idle();
    rs = 5'd0; rt = 5'd0; wr = 5'd0;
    uses_rs = 1'b0; uses_rt = 1'b0; fp_multi = 1'b0;
    mem_read = 1'b0; gpr_wr = 1'b0; fpr_wr = 1'b0; branch = 1'b0; clr = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] dst, input logic [4:0] src, input logic use_it);
    mem_read = 1'b1; gpr_wr = 1'b1; wr = dst; rs = src; uses_rs = use_it;
  endtask

  task automatic clear_cnt();
    idle(); clr = 1'b1; cycle("clr"); clr = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("reset_ctrl_a", {25'd0, pc_a, ifw_a, iff_a, idw_a, idb_a, exb_a, busy_a}, 32'h68);
    check_eq("reset_cnt_a", {28'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();

    // Load-use: one stall cycle, then the load has moved on.
    clear_cnt();
    set_load_use(5'd8, 5'd8, 1'b1);
    cycle("lu");
    check_eq("lu_cnt", {28'd0, cnt_a}, 32'd1);
    idle(); cycle("lu_after");
    set_load_use(5'd0, 5'd0, 1'b1); cycle("lu_r0");
    set_load_use(5'd8, 5'd8, 1'b0); cycle("lu_nouse");
    check_eq("lu_nostall_cnt", {28'd0, cnt_a}, 32'd1);

    // FP op with FP_LAT=4: three freeze cycles.
    clear_cnt();
    fp_multi = 1'b1; cycle("fp_issue");
    fp_multi = 1'b0;
    for (int k = 0; k < 3; k++) cycle("fp_busy");
    check_eq("fp_cnt_a", {28'd0, cnt_a}, 32'd3);
    check_eq("fp_done", {31'd0, busy_a}, 32'd0);
    cycle("fp_run");

    // Branch beats load-use and suppresses FP issue.
    clear_cnt();
    set_load_use(5'd9, 5'd9, 1'b1); branch = 1'b1; fp_multi = 1'b1;
    cycle("br_lu");
    idle();
    check_eq("br_no_issue", {31'd0, busy_a}, 32'd0);
    check_eq("br_no_stall", {28'd0, cnt_a}, 32'd0);
    cycle("br_after");

    // Asynchronous reset in the second freeze cycle.
    fp_multi = 1'b1; cycle("rst_issue");
    fp_multi = 1'b0; cycle("rst_busy1");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_async_pc", {31'd0, pc_a}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();
    check_eq("rst_cnt", {28'd0, cnt_a}, 32'd0);
    cycle("rst_run");

    // Saturation of the 4-bit counter, then clear while still stalling.
    clear_cnt();
    set_load_use(5'd3, 5'd3, 1'b1);
    for (int k = 0; k < 20; k++) cycle("sat");
    check_eq("sat_cnt", {28'd0, cnt_a}, 32'd15);
    clr = 1'b1; cycle("sat_clr");
    check_eq("sat_clr_cnt", {28'd0, cnt_a}, 32'd0);
    idle();

    // Five consecutive FP requests: dut_b never freezes.
    fp_multi = 1'b1;
    for (int k = 0; k < 5; k++) cycle("lat1");
    idle();
    for (int k = 0; k < 4; k++) cycle("lat1_drain");

    // Randomized traffic with small register ranges so dependencies are common.
    for (int k = 0; k < 1500; k++) begin
      rst_n    = 1'b1;
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      wr       = 5'($urandom_range(0, 3));
      uses_rs  = 1'($urandom);
      uses_rt  = 1'($urandom);
      mem_read = 1'($urandom);
      gpr_wr   = 1'($urandom);
      fpr_wr   = ($urandom_range(0, 3) == 0);
      fp_multi = ($urandom_range(0, 2) == 0);
      branch   = ($urandom_range(0, 7) == 0);
      clr      = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
      end
      cycle("rnd");
    end
    rst_n = 1'b1;
    idle();
    cycle("end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
